// File: rtl/rs_csee_sched.sv
// Scheduler in front of the RS decoder's Chien-search / error-evaluation stage:
// queues key-equation results, launches one CSEE pass per codeword and reports a verdict.
module rs_csee_sched #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned BEATS = 24,
  parameter int unsigned QUIET = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rs_ena_in,
  input  logic             kes_valid,
  output logic             kes_ready,
  input  logic [7:0]       kes_lambda0,
  input  logic [7:0]       kes_lambda1,
  input  logic [7:0]       kes_lambda2,
  input  logic [7:0]       kes_omega0,
  input  logic [7:0]       kes_omega1,
  input  logic [TAG_W-1:0] kes_tag,
  output logic             csee_ena,
  output logic             csee_rs_ena,
  output logic [7:0]       csee_lambda0,
  output logic [7:0]       csee_lambda1,
  output logic [7:0]       csee_lambda2,
  output logic [7:0]       csee_omega0,
  output logic [7:0]       csee_omega1,
  input  logic             csee_in_process,
  input  logic             csee_decode_fail,
  output logic             beat_valid,
  output logic [4:0]       beat_idx,
  output logic [TAG_W-1:0] beat_tag,
  output logic             blk_done,
  output logic             blk_fail,
  output logic [TAG_W-1:0] blk_tag,
  output logic             proto_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned QW = $clog2(QUIET + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [QW-1:0] QMAX      = QW'(QUIET);
  localparam logic [4:0]    LAST_BEAT = 5'(BEATS - 1);

  typedef struct packed {
    logic [7:0]       lambda0;
    logic [7:0]       lambda1;
    logic [7:0]       lambda2;
    logic [7:0]       omega0;
    logic [7:0]       omega1;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_TAIL1, S_TAIL2, S_REPORT} state_t;

  entry_t        mem [DEPTH];
  entry_t        hold, head, cur, in_entry;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [QW-1:0] qcnt;
  logic [4:0]    bcnt;
  state_t        state, state_n;
  logic          verdict, perr, push, launch, err_set;

  assign in_entry  = {kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1, kes_tag};
  assign head      = mem[rd_ptr];
  assign kes_ready = rs_ena_in & (count != FULL_CNT);
  assign push      = kes_valid & kes_ready;
  // Launch depends on registers and rs_ena_in only, never on csee_in_process.
  assign launch    = (state == S_IDLE) & (count != '0) & rs_ena_in & (qcnt == QMAX);
  assign csee_ena  = launch;

  // Head drives the CSEE in the launch cycle, hold regs afterwards: same values.
  assign cur          = launch ? head : hold;
  assign csee_lambda0 = cur.lambda0;
  assign csee_lambda1 = cur.lambda1;
  assign csee_lambda2 = cur.lambda2;
  assign csee_omega0  = cur.omega0;
  assign csee_omega1  = cur.omega1;
  assign proto_err    = perr;

  always_comb begin
    state_n    = state;
    beat_valid = 1'b0;
    beat_idx   = '0;
    blk_done   = 1'b0;
    err_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (launch) begin
          beat_valid = 1'b1;
          if (csee_in_process) begin
            state_n = S_RUN;
          end else begin
            err_set = 1'b1;
            state_n = S_REPORT;
          end
        end
      end
      S_RUN: begin
        if (!csee_in_process) begin
          err_set = 1'b1;
          state_n = S_REPORT;
        end else begin
          beat_valid = 1'b1;
          beat_idx   = bcnt;
          if (bcnt == LAST_BEAT) state_n = S_TAIL1;
        end
      end
      S_TAIL1:  state_n = S_TAIL2;
      S_TAIL2:  state_n = S_REPORT;
      S_REPORT: begin
        blk_done = 1'b1;
        state_n  = S_IDLE;
      end
      default:  state_n = S_IDLE;
    endcase
    if (!rs_ena_in) state_n = S_IDLE;
    beat_tag    = beat_valid ? cur.tag : '0;
    blk_fail    = blk_done & verdict;
    blk_tag     = blk_done ? hold.tag : '0;
    // A failing report drops the CSEE enable for one cycle to clear its fail flag.
    csee_rs_ena = rs_ena_in & ~(blk_done & verdict);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      qcnt    <= QMAX;
      bcnt    <= '0;
      hold    <= '0;
      verdict <= 1'b0;
      perr    <= 1'b0;
    end else begin
      state <= state_n;
      if (csee_in_process)   qcnt <= '0;
      else if (qcnt != QMAX) qcnt <= qcnt + QW'(1);
      if (!rs_ena_in) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        perr   <= 1'b0;
      end else begin
        if (push)    wr_ptr <= wr_ptr + AW'(1);
        if (launch)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(launch);
        if (err_set) perr <= 1'b1;
      end
      if (launch) begin
        hold <= head;
        bcnt <= 5'd1;
      end else if (state == S_RUN && csee_in_process) begin
        bcnt <= bcnt + 5'd1;
      end
      if (err_set)               verdict <= 1'b1;
      else if (state == S_TAIL2) verdict <= csee_decode_fail;
    end
  end

endmodule

// File: tb/tb_rs_csee_sched.sv
// Bench for rs_csee_sched: behavioural CSEE responder plus a transaction-level
// reference (queue of codewords, launch timestamps, beat offsets) checked every cycle.
module tb_rs_csee_sched;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned BEATS = 24;
  localparam int unsigned QUIET = 3;

  typedef struct packed {
    logic [7:0] l0, l1, l2, o0, o1;
    logic [3:0] tag;
  } ent_t;

  logic clk, rstn, rs_ena_in, kes_valid, kes_ready;
  ent_t drv;
  logic csee_ena, csee_rs_ena, csee_in_process, csee_decode_fail;
  logic [7:0] csee_lambda0, csee_lambda1, csee_lambda2, csee_omega0, csee_omega1;
  logic beat_valid, blk_done, blk_fail, proto_err;
  logic [4:0] beat_idx;
  logic [TAG_W-1:0] beat_tag, blk_tag;

  rs_csee_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .BEATS(BEATS), .QUIET(QUIET)) dut (
    .clk(clk), .rstn(rstn), .rs_ena_in(rs_ena_in),
    .kes_valid(kes_valid), .kes_ready(kes_ready),
    .kes_lambda0(drv.l0), .kes_lambda1(drv.l1), .kes_lambda2(drv.l2),
    .kes_omega0(drv.o0), .kes_omega1(drv.o1), .kes_tag(drv.tag),
    .csee_ena(csee_ena), .csee_rs_ena(csee_rs_ena),
    .csee_lambda0(csee_lambda0), .csee_lambda1(csee_lambda1), .csee_lambda2(csee_lambda2),
    .csee_omega0(csee_omega0), .csee_omega1(csee_omega1),
    .csee_in_process(csee_in_process), .csee_decode_fail(csee_decode_fail),
    .beat_valid(beat_valid), .beat_idx(beat_idx), .beat_tag(beat_tag),
    .blk_done(blk_done), .blk_fail(blk_fail), .blk_tag(blk_tag), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSEE responder: busy for run_len cycles from launch, sets its fail flag at the
  // end of a pass from fail_tab, clears it whenever csee_rs_ena is low.
  int          run_len = BEATS;
  int          busy;
  logic [15:0] fail_tab;
  logic [3:0]  run_tag;
  logic        fail_flag;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy      <= 0;
      fail_flag <= 1'b0;
      run_tag   <= '0;
    end else begin
      if (csee_ena) begin
        busy    <= run_len - 1;
        run_tag <= beat_tag;
      end else if (busy > 0) begin
        busy <= busy - 1;
      end
      if (!csee_rs_ena)   fail_flag <= 1'b0;
      else if (busy == 1) fail_flag <= fail_tab[run_tag];
    end
  end

  assign csee_in_process  = csee_ena | (busy != 0);
  assign csee_decode_fail = fail_flag;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t q[$];
  ent_t m_hold;
  int   now, m_l, rep_t, last_busy;
  bit   act, aborted, verdict, m_perr, accepted;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: got=%0h expected=%0h", name, now, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_hold    = '0;
    act       = 1'b0;
    aborted   = 1'b0;
    verdict   = 1'b0;
    m_perr    = 1'b0;
    last_busy = -100;
  endtask

  task automatic tick();
    ent_t exp_c;
    logic e_ready, e_ena, e_bv, e_done, e_fail, in_beat;
    logic [4:0] e_idx;
    logic [3:0] e_btag;
    int o;
    @(negedge clk);
    o       = now - m_l;
    e_ready = rs_ena_in && (q.size() < DEPTH);
    e_ena   = rstn && !act && (q.size() > 0) && rs_ena_in && (now - last_busy > QUIET);
    in_beat = act && !aborted && o >= 1 && o < BEATS;
    exp_c   = m_hold;
    e_bv    = 1'b0;
    e_idx   = '0;
    e_btag  = '0;
    if (e_ena) begin
      exp_c  = q[0];
      e_bv   = 1'b1;
      e_btag = q[0].tag;
    end else if (in_beat && csee_in_process) begin
      e_bv   = 1'b1;
      e_idx  = 5'(o);
      e_btag = m_hold.tag;
    end
    e_done = act && now == rep_t;
    e_fail = e_done && verdict;
    chk("kes_ready", kes_ready, e_ready);
    chk("csee_ena", csee_ena, e_ena);
    chk("csee_poly", {csee_lambda0, csee_lambda1, csee_lambda2, csee_omega0, csee_omega1},
        {exp_c.l0, exp_c.l1, exp_c.l2, exp_c.o0, exp_c.o1});
    chk("beat", {beat_valid, beat_idx, beat_tag}, {e_bv, e_idx, e_btag});
    chk("blk", {blk_done, blk_fail, blk_tag}, {e_done, e_fail, e_done ? m_hold.tag : 4'h0});
    chk("csee_rs_ena", csee_rs_ena, rs_ena_in && !e_fail);
    chk("proto_err", proto_err, m_perr);
    if (csee_in_process) last_busy = now;
    if (!rs_ena_in) begin
      q.delete();
      act    = 1'b0;
      m_perr = 1'b0;
    end else begin
      if (e_done) begin
        act = 1'b0;
      end else if (in_beat && !csee_in_process) begin
        aborted = 1'b1; rep_t = now + 1; m_perr = 1'b1; verdict = 1'b1;
      end
      if (e_ena) begin
        m_hold  = q.pop_front();
        act     = 1'b1;
        m_l     = now;
        aborted = 1'b0;
        if (!csee_in_process) begin
          aborted = 1'b1; rep_t = now + 1; m_perr = 1'b1; verdict = 1'b1;
        end else begin
          rep_t   = now + BEATS + 2;
          verdict = fail_tab[m_hold.tag];
        end
      end
      if (kes_valid && e_ready) q.push_back(drv);
    end
    accepted = kes_valid && e_ready;
    now++;
    @(posedge clk);
    #1;
  endtask

  task automatic push_ent(input ent_t e);
    drv       = e;
    kes_valid = 1'b1;
    accepted  = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (accepted) break;
    end
    kes_valid = 1'b0;
    chk("push_accept", accepted, 1'b1);
  endtask

  task automatic push_rand(input logic [3:0] t);
    ent_t e;
    e.l0 = 8'($urandom()); e.l1 = 8'($urandom()); e.l2 = 8'($urandom());
    e.o0 = 8'($urandom()); e.o1 = 8'($urandom()); e.tag = t;
    push_ent(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_beat(input int n);
    bit found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (act && !aborted && now - m_l == n) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_beat", found, 1'b1);
  endtask

  initial begin
    ent_t e0;
    now       = 0;
    m_l       = 0;
    rep_t     = 0;
    fail_tab  = 16'h0020;
    rs_ena_in = 1'b1;
    kes_valid = 1'b0;
    drv       = '0;
    rstn      = 1'b1;
    model_reset();
    #1 rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
    idle(2);

    // Single codeword with the fixed polynomial
    e0 = {8'h01, 8'h1D, 8'h00, 8'h05, 8'h00, 4'd3};
    push_ent(e0);
    idle(30);

    // Three back-to-back codewords: FIFO fills, 27-cycle launch period
    push_rand(4'd1);
    push_rand(4'd2);
    push_rand(4'd3);
    idle(90);

    // Failing codeword then a clean one
    push_rand(4'd5);
    push_rand(4'd6);
    idle(60);

    // CSEE drops busy at beat 10; proto_err sticks until enable drops
    run_len = 10;
    push_rand(4'd7);
    run_len = BEATS;
    idle(20);
    push_rand(4'd8);
    idle(32);
    rs_ena_in = 1'b0;
    tick();
    rs_ena_in = 1'b1;
    idle(4);

    // Enable dropped at beat 12 with one entry queued
    push_rand(4'd9);
    push_rand(4'd10);
    wait_beat(12);
    rs_ena_in = 1'b0;
    idle(3);
    rs_ena_in = 1'b1;
    push_rand(4'd11);
    idle(40);

    // Asynchronous reset in the middle of a pass
    push_rand(4'd12);
    wait_beat(5);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_ctl", {csee_ena, kes_ready, csee_rs_ena, beat_valid, beat_idx, beat_tag,
                          blk_done, blk_fail, blk_tag, proto_err},
        {1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0});
    chk("async_rst_poly", {csee_lambda0, csee_lambda1, csee_lambda2, csee_omega0, csee_omega1},
        40'h0);
    model_reset();
    idle(2);
    rstn = 1'b1;
    push_rand(4'd13);
    idle(30);

    // Random codewords, tags, gaps and verdicts
    fail_tab = 16'($urandom());
    for (int i = 0; i < 8; i++) begin
      push_rand(4'($urandom_range(0, 15)));
      idle(int'($urandom_range(0, 35)));
    end
    idle(90);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
